// File: rtl/player_action_fsm.sv
// player_action_fsm
// Player action controller for a 60 Hz game tick: waits for a confirm press,
// then walks left/right with saturating position, runs a three-phase attack
// (startup / active / recovery) with a registered hitbox, and drops into a
// fixed-length stun whenever the player is struck.
// Optional feature: define ATTACK_BUFFER_EN to let an attack pressed during
// recovery chain straight into a new attack when recovery ends.
module player_action_fsm #(
  parameter logic [9:0] X_MIN      = 10'd0,
  parameter logic [9:0] X_MAX      = 10'd600,
  parameter logic [9:0] X_START    = 10'd100,
  parameter logic [9:0] STEP       = 10'd2,
  parameter logic [3:0] T_STARTUP  = 4'd4,
  parameter logic [3:0] T_ACTIVE   = 4'd3,
  parameter logic [3:0] T_RECOVERY = 4'd8
) (
  input  logic       clk_60Hz_game,
  input  logic       reset,
  input  logic       move_left_cmd_in,
  input  logic       move_right_cmd_in,
  input  logic       attack_cmd_in,
  input  logic       confirm_cmd_in,
  input  logic       hit_stun_in,
  output logic [2:0] state_out,
  output logic [9:0] pos_x_out,
  output logic       facing_right_out,
  output logic       attack_hitbox_out
);

  typedef enum logic [2:0] {
    WAIT         = 3'd0,
    IDLE         = 3'd1,
    WALK_L       = 3'd2,
    WALK_R       = 3'd3,
    ATK_STARTUP  = 3'd4,
    ATK_ACTIVE   = 3'd5,
    ATK_RECOVERY = 3'd6,
    STUN         = 3'd7
  } state_t;

  // Stun lasts 12 ticks; the counter holds "ticks remaining minus one".
  localparam logic [3:0] STUN_LOAD = 4'd11;

  state_t      state, state_next;
  logic [9:0]  pos, pos_next;
  logic        facing, facing_next;
  logic        hitbox;
  logic [3:0]  phase_cnt, phase_cnt_next;
  logic [3:0]  stun_cnt, stun_cnt_next;
  logic        attack_buffer, buffer_next;
  logic        attack_prev, confirm_prev;
  logic        attack_edge, confirm_edge;
  logic [10:0] pos_inc, left_floor;
  logic [9:0]  pos_right, pos_left;

  assign attack_edge  = attack_cmd_in & ~attack_prev;
  assign confirm_edge = confirm_cmd_in & ~confirm_prev;

  assign state_out         = state;
  assign pos_x_out         = pos;
  assign facing_right_out  = facing;
  assign attack_hitbox_out = hitbox;

  // Previous-tick copies of attack and confirm for rising-edge detection.
  always_ff @(posedge clk_60Hz_game or posedge reset) begin
    if (reset) begin
      attack_prev  <= 1'b0;
      confirm_prev <= 1'b0;
    end else begin
      attack_prev  <= attack_cmd_in;
      confirm_prev <= confirm_cmd_in;
    end
  end

  // One-step neighbours of the current position, clamped in 11 bits so nothing wraps.
  always_comb begin
    pos_inc    = {1'b0, pos} + {1'b0, STEP};
    left_floor = {1'b0, X_MIN} + {1'b0, STEP};
    pos_right  = (pos_inc > {1'b0, X_MAX}) ? X_MAX : pos_inc[9:0];
    pos_left   = ({1'b0, pos} < left_floor) ? X_MIN : (pos - STEP);
  end

  // Next-state and datapath decisions; a hit overrides everything except WAIT.
  always_comb begin
    state_next     = state;
    pos_next       = pos;
    facing_next    = facing;
    phase_cnt_next = phase_cnt;
    stun_cnt_next  = stun_cnt;
    buffer_next    = attack_buffer;

    if ((state != WAIT) && hit_stun_in) begin
      state_next     = STUN;
      stun_cnt_next  = STUN_LOAD;
      phase_cnt_next = 4'd0;
      buffer_next    = 1'b0;
    end else begin
      case (state)
        WAIT: begin
          pos_next = X_START;
          if (confirm_edge) begin
            state_next = IDLE;
          end
        end
        IDLE, WALK_L, WALK_R: begin
          if (attack_edge) begin
            state_next     = ATK_STARTUP;
            phase_cnt_next = T_STARTUP - 4'd1;
          end else if (move_left_cmd_in && !move_right_cmd_in) begin
            state_next  = WALK_L;
            pos_next    = pos_left;
            facing_next = 1'b0;
          end else if (move_right_cmd_in && !move_left_cmd_in) begin
            state_next  = WALK_R;
            pos_next    = pos_right;
            facing_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        ATK_STARTUP: begin
          if (phase_cnt == 4'd0) begin
            state_next     = ATK_ACTIVE;
            phase_cnt_next = T_ACTIVE - 4'd1;
          end else begin
            phase_cnt_next = phase_cnt - 4'd1;
          end
        end
        ATK_ACTIVE: begin
          if (phase_cnt == 4'd0) begin
            state_next     = ATK_RECOVERY;
            phase_cnt_next = T_RECOVERY - 4'd1;
          end else begin
            phase_cnt_next = phase_cnt - 4'd1;
          end
        end
        ATK_RECOVERY: begin
`ifdef ATTACK_BUFFER_EN
          if (attack_edge) begin
            buffer_next = 1'b1;
          end
`else
`endif
          if (phase_cnt == 4'd0) begin
            if (buffer_next) begin
              state_next     = ATK_STARTUP;
              phase_cnt_next = T_STARTUP - 4'd1;
              buffer_next    = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            phase_cnt_next = phase_cnt - 4'd1;
          end
        end
        STUN: begin
          if (stun_cnt == 4'd0) begin
            state_next = IDLE;
          end else begin
            stun_cnt_next = stun_cnt - 4'd1;
          end
        end
        default: begin
          state_next = WAIT;
        end
      endcase
    end
  end

  // State, position, facing, counters and the registered hitbox.
  always_ff @(posedge clk_60Hz_game or posedge reset) begin
    if (reset) begin
      state         <= WAIT;
      pos           <= X_START;
      facing        <= 1'b1;
      hitbox        <= 1'b0;
      phase_cnt     <= 4'd0;
      stun_cnt      <= 4'd0;
      attack_buffer <= 1'b0;
    end else begin
      state         <= state_next;
      pos           <= pos_next;
      facing        <= facing_next;
      hitbox        <= (state_next == ATK_ACTIVE);
      phase_cnt     <= phase_cnt_next;
      stun_cnt      <= stun_cnt_next;
      attack_buffer <= buffer_next;
    end
  end

endmodule

// File: tb/tb_player_action_fsm.sv
// tb_player_action_fsm
// Directed vector table, hand-written corner sequences (saturation, async reset
// mid-attack) and a randomized run against a behavioural player model.
// Build with ATTACK_BUFFER_EN defined to exercise the attack buffer.
`timescale 1ns/1ps
module tb_player_action_fsm;

  localparam int X_MIN   = 0;
  localparam int X_MAX   = 600;
  localparam int X_START = 100;
  localparam int STEP    = 2;
  localparam int T_SU    = 4;
  localparam int T_AC    = 3;
  localparam int T_RE    = 8;
  localparam int T_STUN  = 12;

  localparam int S_WAIT = 0, S_IDLE = 1, S_WL = 2, S_WR = 3;
  localparam int S_SU = 4, S_AC = 5, S_RE = 6, S_STUN = 7;

`ifdef ATTACK_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic       clk_60Hz_game = 1'b0;
  logic       reset = 1'b1;
  logic       move_left_cmd_in = 1'b0;
  logic       move_right_cmd_in = 1'b0;
  logic       attack_cmd_in = 1'b0;
  logic       confirm_cmd_in = 1'b0;
  logic       hit_stun_in = 1'b0;
  logic [2:0] state_out;
  logic [9:0] pos_x_out;
  logic       facing_right_out;
  logic       attack_hitbox_out;
  logic [2:0] odd_state;
  logic [9:0] odd_pos;
  logic       odd_facing;
  logic       odd_hitbox;

  int errors = 0;
  int checks = 0;

  player_action_fsm dut (
    .clk_60Hz_game     (clk_60Hz_game),
    .reset             (reset),
    .move_left_cmd_in  (move_left_cmd_in),
    .move_right_cmd_in (move_right_cmd_in),
    .attack_cmd_in     (attack_cmd_in),
    .confirm_cmd_in    (confirm_cmd_in),
    .hit_stun_in       (hit_stun_in),
    .state_out         (state_out),
    .pos_x_out         (pos_x_out),
    .facing_right_out  (facing_right_out),
    .attack_hitbox_out (attack_hitbox_out)
  );

  player_action_fsm #(.X_START(10'd599)) dut_odd (
    .clk_60Hz_game     (clk_60Hz_game),
    .reset             (reset),
    .move_left_cmd_in  (move_left_cmd_in),
    .move_right_cmd_in (move_right_cmd_in),
    .attack_cmd_in     (attack_cmd_in),
    .confirm_cmd_in    (confirm_cmd_in),
    .hit_stun_in       (hit_stun_in),
    .state_out         (odd_state),
    .pos_x_out         (odd_pos),
    .facing_right_out  (odd_facing),
    .attack_hitbox_out (odd_hitbox)
  );

  // 60 Hz game tick stand-in
  always #5 clk_60Hz_game = ~clk_60Hz_game;

  typedef struct {
    logic left, right, attack, confirm, stun;
    int   exp_state;
    int   exp_pos;
    logic exp_face;
    logic exp_hit;
  } vec_t;

  vec_t vecs[$];

  int   m_state, m_pos, m_left;
  logic m_face, m_hit, m_atk_prev, m_conf_prev, m_buf;

  function automatic void addVec(input logic l, r, a, c, s, input int st, input int p,
                                 input logic f, input logic h);
    vec_t v;
    v.left = l; v.right = r; v.attack = a; v.confirm = c; v.stun = s;
    v.exp_state = st; v.exp_pos = p; v.exp_face = f; v.exp_hit = h;
    vecs.push_back(v);
  endfunction

  task automatic checkVal(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input int st, input int p,
                             input logic f, input logic h);
    checkVal({tag, " state"}, int'(state_out), st);
    checkVal({tag, " pos"}, int'(pos_x_out), p);
    checkVal({tag, " facing"}, int'(facing_right_out), int'(f));
    checkVal({tag, " hitbox"}, int'(attack_hitbox_out), int'(h));
  endtask

  task automatic applyStimulus(input logic l, r, a, c, s);
    @(negedge clk_60Hz_game);
    move_left_cmd_in  = l;
    move_right_cmd_in = r;
    attack_cmd_in     = a;
    confirm_cmd_in    = c;
    hit_stun_in       = s;
    @(posedge clk_60Hz_game);
    #1;
  endtask

  task automatic doReset();
    move_left_cmd_in  = 1'b0;
    move_right_cmd_in = 1'b0;
    attack_cmd_in     = 1'b0;
    confirm_cmd_in    = 1'b0;
    hit_stun_in       = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk_60Hz_game);
    @(negedge clk_60Hz_game);
    reset = 1'b0;
  endtask

  task automatic modelReset();
    m_state = S_WAIT; m_pos = X_START; m_face = 1'b1; m_hit = 1'b0;
    m_left = 0; m_atk_prev = 1'b0; m_conf_prev = 1'b0; m_buf = 1'b0;
  endtask

  task automatic modelStep(input logic l, r, a, c, s);
    logic ae, ce;
    ae = a && !m_atk_prev;
    ce = c && !m_conf_prev;
    m_atk_prev  = a;
    m_conf_prev = c;
    if (m_state != S_WAIT && s) begin
      m_state = S_STUN; m_left = T_STUN; m_buf = 1'b0;
    end else begin
      case (m_state)
        S_WAIT: if (ce) begin m_state = S_IDLE; m_pos = X_START; end
        S_IDLE, S_WL, S_WR: begin
          if (ae) begin
            m_state = S_SU; m_left = T_SU;
          end else if (l && !r) begin
            m_state = S_WL; m_face = 1'b0;
            m_pos = (m_pos - STEP < X_MIN) ? X_MIN : m_pos - STEP;
          end else if (r && !l) begin
            m_state = S_WR; m_face = 1'b1;
            m_pos = (m_pos + STEP > X_MAX) ? X_MAX : m_pos + STEP;
          end else begin
            m_state = S_IDLE;
          end
        end
        S_SU, S_AC, S_RE: begin
          if (m_state == S_RE && ae && BUF_EN) m_buf = 1'b1;
          m_left--;
          if (m_left == 0) begin
            if (m_state == S_SU) begin m_state = S_AC; m_left = T_AC; end
            else if (m_state == S_AC) begin m_state = S_RE; m_left = T_RE; end
            else if (m_buf) begin m_buf = 1'b0; m_state = S_SU; m_left = T_SU; end
            else m_state = S_IDLE;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_state = S_IDLE;
        end
      endcase
    end
    m_hit = (m_state == S_AC);
  endtask

  initial begin
    logic l, r, a, c, s;
    int   after_buf;

    $display("[TB] start, attack buffer %0d", BUF_EN);
    after_buf = BUF_EN ? S_SU : S_IDLE;

    addVec(0,0,0,0,0, S_WAIT, 100, 1, 0);
    addVec(1,0,1,0,1, S_WAIT, 100, 1, 0);
    addVec(0,0,0,1,0, S_IDLE, 100, 1, 0);
    addVec(0,0,0,1,0, S_IDLE, 100, 1, 0);
    for (int k = 1; k <= 10; k++) addVec(0,1,0,0,0, S_WR, 100 + 2*k, 1, 0);
    addVec(1,1,0,0,0, S_IDLE, 120, 1, 0);
    addVec(1,1,0,0,0, S_IDLE, 120, 1, 0);
    addVec(1,0,0,0,0, S_WL, 118, 0, 0);
    for (int k = 0; k < 4; k++) addVec(1,0,1,0,0, S_SU, 118, 0, 0);
    for (int k = 0; k < 3; k++) addVec(1,0,1,0,0, S_AC, 118, 0, 1);
    for (int k = 0; k < 8; k++) addVec(1,0,1,0,0, S_RE, 118, 0, 0);
    addVec(0,0,1,0,0, S_IDLE, 118, 0, 0);
    addVec(0,0,1,0,0, S_IDLE, 118, 0, 0);
    addVec(0,0,0,0,0, S_IDLE, 118, 0, 0);
    addVec(0,0,1,0,0, S_SU, 118, 0, 0);
    for (int k = 0; k < 3; k++) addVec(0,0,0,0,0, S_SU, 118, 0, 0);
    addVec(0,0,0,0,0, S_AC, 118, 0, 1);
    addVec(0,0,0,0,0, S_AC, 118, 0, 1);
    addVec(0,0,0,0,1, S_STUN, 118, 0, 0);
    for (int k = 0; k < 4; k++) addVec(0,0,0,0,0, S_STUN, 118, 0, 0);
    addVec(0,0,0,0,1, S_STUN, 118, 0, 0);
    addVec(0,0,0,0,0, S_STUN, 118, 0, 0);
    addVec(0,0,0,0,0, S_STUN, 118, 0, 0);
    addVec(0,0,1,0,0, S_STUN, 118, 0, 0);
    addVec(0,0,0,0,0, S_STUN, 118, 0, 0);
    addVec(1,0,0,0,0, S_STUN, 118, 0, 0);
    for (int k = 0; k < 6; k++) addVec(0,0,0,0,0, S_STUN, 118, 0, 0);
    addVec(0,0,0,0,0, S_IDLE, 118, 0, 0);
    addVec(0,0,0,1,0, S_IDLE, 118, 0, 0);
    addVec(0,0,0,0,0, S_IDLE, 118, 0, 0);
    addVec(0,0,1,0,0, S_SU, 118, 0, 0);
    for (int k = 0; k < 3; k++) addVec(0,0,0,0,0, S_SU, 118, 0, 0);
    for (int k = 0; k < 3; k++) addVec(0,0,0,0,0, S_AC, 118, 0, 1);
    addVec(0,0,0,0,0, S_RE, 118, 0, 0);
    addVec(0,0,0,0,0, S_RE, 118, 0, 0);
    addVec(0,0,0,0,0, S_RE, 118, 0, 0);
    addVec(0,0,1,0,0, S_RE, 118, 0, 0);
    for (int k = 0; k < 4; k++) addVec(0,0,0,0,0, S_RE, 118, 0, 0);
    for (int k = 0; k < 3; k++) addVec(0,0,0,0,0, after_buf, 118, 0, 0);

    doReset();
    checkOutput("reset", S_WAIT, 100, 1, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].left, vecs[i].right, vecs[i].attack, vecs[i].confirm, vecs[i].stun);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_pos,
                  vecs[i].exp_face, vecs[i].exp_hit);
    end

    doReset();
    applyStimulus(0,0,0,1,0);
    checkVal("odd start pos", int'(odd_pos), 599);
    for (int k = 1; k <= 251; k++) begin
      applyStimulus(0,1,0,0,0);
      if (k <= 2) checkVal($sformatf("odd sat pos k%0d", k), int'(odd_pos), 600);
      if (k == 249) checkOutput("walk r 249", S_WR, 598, 1, 0);
      if (k >= 250) checkOutput($sformatf("sat r %0d", k), S_WR, 600, 1, 0);
    end
    for (int k = 1; k <= 302; k++) begin
      applyStimulus(1,0,0,0,0);
      if (k >= 300) checkOutput($sformatf("sat l %0d", k), S_WL, 0, 0, 0);
    end

    doReset();
    applyStimulus(0,0,0,1,0);
    applyStimulus(0,0,1,0,0);
    repeat (4) applyStimulus(0,0,1,0,0);
    checkOutput("pre reset active", S_AC, 100, 1, 1);
    #2 reset = 1'b1;
    #1 checkOutput("async reset", S_WAIT, 100, 1, 0);
    @(negedge clk_60Hz_game);
    reset = 1'b0;
    applyStimulus(0,0,0,0,0);
    checkOutput("after reset", S_WAIT, 100, 1, 0);

    doReset();
    modelReset();
    l = 0; r = 0; a = 0; c = 0; s = 0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0) l = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) a = ~a;
      if ($urandom_range(0, 19) == 0) c = ~c;
      s = ($urandom_range(0, 59) == 0);
      applyStimulus(l, r, a, c, s);
      modelStep(l, r, a, c, s);
      checkOutput($sformatf("rand%0d", t), m_state, m_pos, m_face, m_hit);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_action_fsm.md
PLAYER_ACTION_FSM -- requirements
Module: player_action_fsm

Interface
REQ-001 Parameter X_MIN, default 10'd0: leftmost legal pos_x_out.
REQ-002 Parameter X_MAX, default 10'd600: rightmost legal pos_x_out.
REQ-003 Parameter X_START, default 10'd100: position loaded at reset and on game start.
REQ-004 Parameter STEP, default 10'd2: pixels moved per walk tick.
REQ-005 Parameter T_STARTUP / T_ACTIVE / T_RECOVERY, defaults 4 / 3 / 8: attack phase lengths in ticks, each 1..15.
REQ-006 Port list, one per line:
  clk_60Hz_game  in  1  game tick clock
  reset  in  1  async, active-high
  move_left_cmd_in  in  1  active-high level, left held
  move_right_cmd_in  in  1  active-high level, right held
  attack_cmd_in  in  1  active-high level, attack held
  confirm_cmd_in  in  1  active-high level, confirm held
  hit_stun_in  in  1  one-tick pulse, player was struck
  state_out  out  3  current state code
  pos_x_out  out  10  player x position
  facing_right_out  out  1  1 = facing right
  attack_hitbox_out  out  1  high only in ATK_ACTIVE
REQ-007 Reset is reset, asynchronous, active-high; clock is clk_60Hz_game.

Function
REQ-008 States/codes: WAIT=0, IDLE=1, WALK_L=2, WALK_R=3, ATK_STARTUP=4, ATK_ACTIVE=5, ATK_RECOVERY=6, STUN=7.
REQ-009 Attack and confirm are rising-edge detected internally (registered previous value); holding does not retrigger.
REQ-010 WAIT: hold pos_x_out=X_START; confirm edge -> IDLE next tick; all other inputs ignored.
REQ-011 IDLE/WALK_L/WALK_R: priority hit_stun_in > attack edge > movement; exactly one of left/right held -> WALK_L/WALK_R; both or neither -> IDLE.
REQ-012 WALK_L: each tick pos -= STEP, saturating at X_MIN; facing_right_out=0. WALK_R: pos += STEP, saturating at X_MAX; facing_right_out=1.
REQ-013 Saturation computed in 11-bit arithmetic; pos_x_out never leaves [X_MIN, X_MAX], never wraps.
REQ-014 Attack edge -> ATK_STARTUP, phase counter loaded; ATK_STARTUP lasts T_STARTUP ticks, ATK_ACTIVE T_ACTIVE, ATK_RECOVERY T_RECOVERY, then IDLE.
REQ-015 During attack phases position and facing are frozen; movement inputs ignored.
REQ-016 hit_stun_in in any state except WAIT -> STUN for 12 ticks, aborting any attack (hitbox drops same tick); then IDLE.
REQ-017 hit_stun_in during STUN restarts the 12-tick count.
REQ-018 attack_hitbox_out is registered, asserted exactly T_ACTIVE ticks per uninterrupted attack.
REQ-019 Confirm edge outside WAIT is ignored.

Reset
REQ-020 On reset: state WAIT, pos_x_out=X_START, facing_right_out=1, attack_hitbox_out=0, phase/stun counters 0, edge-detect registers 0, buffer flag 0.
REQ-021 Reset asserted mid-attack or mid-stun aborts immediately; no output glitch after deassertion.

Configuration
REQ-022 Macro ATTACK_BUFFER_EN: when defined, an attack edge during ATK_RECOVERY sets a one-entry buffer; at recovery end FSM enters ATK_STARTUP instead of IDLE and buffer clears; hit_stun_in clears the buffer.
REQ-023 Without ATTACK_BUFFER_EN, attack edges during any attack phase or STUN are discarded.

Verification
REQ-024 Reset, then confirm pulse -> state WAIT(0) then IDLE(1) one tick after edge; pos_x_out=100.
REQ-025 Hold right 10 ticks from pos 100 -> pos_x_out=120, facing_right_out=1; hold right at 599 -> 600, stays 600.
REQ-026 Attack edge from IDLE -> states 4,5,6 for 4/3/8 ticks, hitbox high exactly 3 ticks, then IDLE; holding attack gives no second attack.
REQ-027 hit_stun_in on 2nd ATK_ACTIVE tick -> hitbox 0 and state 7 next tick, IDLE after 12 ticks.
REQ-028 Both left and right held in IDLE -> stays IDLE, pos unchanged.
REQ-029 With ATTACK_BUFFER_EN, attack edge in recovery tick 3 -> ATK_STARTUP immediately after recovery; without macro -> IDLE.
